key_conditioner: RTL and testbench

- Conditions the raw push-button inputs KEY[1:0] before they reach the CLOCK1 time-setting logic. It sits directly upstream of CLOCK1.
- Per key it provides: a 2-FF synchroniser, a debounce filter, a press one-shot, a release one-shot, and auto-repeat while a key is held.
- CLOCK1 consumes PULSE for increment/step and LONG for fast-set mode.

---
 rtl/key_conditioner.sv | 168 ++++++++++++++++
 tb/tb_key_conditioner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Push-button conditioner for the CLOCK1 time-setting keys: per-key synchroniser,
// debounce filter, press/release one-shots and auto-repeat with a long-hold flag.
module key_conditioner #(
  parameter int unsigned N_KEYS           = 2,
  parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYC = 25_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 5_000_000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] PRESSED,
  output logic [N_KEYS-1:0] PULSE,
  output logic [N_KEYS-1:0] RELEASE,
  output logic [N_KEYS-1:0] LONG
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                      : REPEAT_RATE_CYC;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY_CYC - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD_WAIT,
    REPEAT
  } state_t;

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] disagree;
  logic [N_KEYS-1:0] acc_press;
  logic [N_KEYS-1:0] acc_release;
  logic [DW-1:0]     db_cnt [N_KEYS];

  state_t            state      [N_KEYS];
  state_t            state_nx   [N_KEYS];
  logic [RW-1:0]     rpt_cnt    [N_KEYS];
  logic [RW-1:0]     rpt_cnt_nx [N_KEYS];
  logic [N_KEYS-1:0] pulse_nx;
  logic [N_KEYS-1:0] release_nx;
  logic [N_KEYS-1:0] long_nx;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  // sync2 is active-low and level active-high, so equal bits mean the input disagrees.
  assign disagree = sync2 ~^ level;

  always_comb begin
    acc_press   = '0;
    acc_release = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (disagree[i] && (db_cnt[i] == DB_LAST)) begin
        acc_press[i]   = ~level[i];
        acc_release[i] = level[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      level <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (!disagree[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= ~level[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Release is tested before the repeat boundary so a coincident release suppresses the pulse.
  always_comb begin
    pulse_nx   = '0;
    release_nx = '0;
    long_nx    = LONG;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      state_nx[i]   = state[i];
      rpt_cnt_nx[i] = rpt_cnt[i];
      case (state[i])
        IDLE: begin
          if (acc_press[i]) begin
            pulse_nx[i]   = 1'b1;
            rpt_cnt_nx[i] = '0;
            state_nx[i]   = HELD_WAIT;
          end
        end
        HELD_WAIT: begin
          if (acc_release[i]) begin
            release_nx[i] = 1'b1;
            long_nx[i]    = 1'b0;
            rpt_cnt_nx[i] = '0;
            state_nx[i]   = IDLE;
          end else if (rpt_cnt[i] == RD_LAST) begin
            pulse_nx[i]   = 1'b1;
            long_nx[i]    = 1'b1;
            rpt_cnt_nx[i] = '0;
            state_nx[i]   = REPEAT;
          end else begin
            rpt_cnt_nx[i] = rpt_cnt[i] + 1'b1;
          end
        end
        REPEAT: begin
          if (acc_release[i]) begin
            release_nx[i] = 1'b1;
            long_nx[i]    = 1'b0;
            rpt_cnt_nx[i] = '0;
            state_nx[i]   = IDLE;
          end else if (rpt_cnt[i] == RR_LAST) begin
            pulse_nx[i]   = 1'b1;
            rpt_cnt_nx[i] = '0;
          end else begin
            rpt_cnt_nx[i] = rpt_cnt[i] + 1'b1;
          end
        end
        default: begin
          long_nx[i]    = 1'b0;
          rpt_cnt_nx[i] = '0;
          state_nx[i]   = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PULSE   <= '0;
      RELEASE <= '0;
      LONG    <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        state[i]   <= IDLE;
        rpt_cnt[i] <= '0;
      end
    end else begin
      PULSE   <= pulse_nx;
      RELEASE <= release_nx;
      LONG    <= long_nx;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        state[i]   <= state_nx[i];
        rpt_cnt[i] <= rpt_cnt_nx[i];
      end
    end
  end

  assign PRESSED = level;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key activity, checked
// every cycle against a sample-window / hold-age reference model.
module tb_key_conditioner;

  localparam int unsigned NK = 2;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RR = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key;
  logic [NK-1:0] pressed;
  logic [NK-1:0] pulse;
  logic [NK-1:0] rel;
  logic [NK-1:0] lng;

  int total = 0;
  int bad   = 0;
  int pc0   = 0;
  int rc0   = 0;
  int act1  = 0;

  key_conditioner #(
    .N_KEYS(NK),
    .DEBOUNCE_CYC(DB),
    .REPEAT_DELAY_CYC(RD),
    .REPEAT_RATE_CYC(RR)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .KEY(key),
    .PRESSED(pressed),
    .PULSE(pulse),
    .RELEASE(rel),
    .LONG(lng)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples per edge, accepted level from a D-sample window,
  // pulses from the age of the current hold.
  bit [NK-1:0] hist[$];
  bit [NK-1:0] m_stable;
  bit [NK-1:0] m_pulse;
  bit [NK-1:0] m_rel;
  bit [NK-1:0] m_long;
  int          m_n;
  int          m_tacc [NK];

  task automatic model_clear();
    hist.delete();
    for (int j = 0; j < DB + 2; j++) hist.push_back('1);
    m_stable = '0;
    m_pulse  = '0;
    m_rel    = '0;
    m_long   = '0;
    m_n      = 0;
    for (int i = 0; i < NK; i++) m_tacc[i] = 0;
  endtask

  task automatic model_step(input bit [NK-1:0] k);
    bit [NK-1:0] h;
    bit          flip;
    int          age;
    hist.push_back(k);
    void'(hist.pop_front());
    m_n++;
    m_pulse = '0;
    m_rel   = '0;
    for (int i = 0; i < NK; i++) begin
      flip = 1'b1;
      for (int j = 0; j < DB; j++) begin
        h = hist[j];
        if (bit'(~h[i]) == m_stable[i]) flip = 1'b0;
      end
      if (flip) begin
        m_stable[i] = ~m_stable[i];
        if (m_stable[i]) begin
          m_tacc[i]  = m_n;
          m_pulse[i] = 1'b1;
        end else begin
          m_rel[i]  = 1'b1;
          m_long[i] = 1'b0;
        end
      end else if (m_stable[i]) begin
        age = m_n - m_tacc[i];
        if (age >= int'(RD) && ((age - int'(RD)) % int'(RR)) == 0) m_pulse[i] = 1'b1;
        m_long[i] = (age >= int'(RD));
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_clear();
    else        model_step(key);
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("pressed", {6'b0, pressed}, {6'b0, m_stable});
    check("pulse",   {6'b0, pulse},   {6'b0, m_pulse});
    check("release", {6'b0, rel},     {6'b0, m_rel});
    check("long",    {6'b0, lng},     {6'b0, m_long});
    if (pulse[0]) pc0++;
    if (rel[0])   rc0++;
    if (pulse[1] | rel[1] | pressed[1]) act1++;
  end

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    key   = 2'b11;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    cycles(3);
    check("rst_idle", {pressed, pulse, rel, lng}, 8'h00);

    // key 0 held through reset: one fresh press after release of reset
    key = 2'b10;
    cycles(2);
    check("rst_held_quiet", {pressed, pulse, rel, lng}, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    pc0 = 0;
    cycles(12);
    check("rst_held_pulse", 8'(pc0), 8'd1);
    key = 2'b11;
    cycles(12);

    // clean press and release
    key = 2'b10;
    cycles(12);
    key = 2'b11;
    cycles(12);

    // bounces shorter than the filter on key 1
    act1 = 0;
    key = 2'b01; cycles(1);
    key = 2'b11; cycles(1);
    key = 2'b01; cycles(2);
    key = 2'b11; cycles(1);
    key = 2'b01; cycles(3);
    key = 2'b11; cycles(10);
    check("bounce_quiet", 8'(act1), 8'd0);

    // auto-repeat; release lands on the t+60 repeat boundary and must win
    pc0 = 0;
    rc0 = 0;
    key = 2'b10;
    cycles(60);
    key = 2'b11;
    cycles(12);
    check("repeat_pulses", 8'(pc0), 8'd6);
    check("repeat_release", 8'(rc0), 8'd1);

    // both keys together
    key = 2'b00;
    cycles(40);
    key = 2'b11;
    cycles(12);

    // asynchronous reset in the middle of auto-repeat
    rc0 = 0;
    key = 2'b10;
    cycles(35);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_clear", {pressed, pulse, rel, lng}, 8'h00);
    cycles(2);
    @(negedge clk);
    #2 rst_n = 1'b1;
    pc0 = 0;
    cycles(10);
    check("rst_fresh_press", 8'(pc0), 8'd1);
    check("rst_no_release", 8'(rc0), 8'd0);
    key = 2'b11;
    cycles(12);

    // random key activity with occasional short resets
    for (int s = 0; s < 50; s++) begin
      key = 2'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      cycles(int'($urandom_range(1, 45)));
    end
    key = 2'b11;
    cycles(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
